// File: rtl/alu_div8_seq.sv
// alu_div8_seq - sequential restoring divider for the 8-bit ALU.
//
// Computes unsigned a / b, one trial subtraction per clock, with ready/valid
// handshakes on both the operand side and the result side.
//
// Ports:
//   clk          in   1      clock, all state changes on the rising edge
//   rst_n        in   1      synchronous active-low reset
//   start_valid  in   1      operands a, b are valid
//   start_ready  out  1      divider can accept operands (IDLE only)
//   a            in   WIDTH  dividend
//   b            in   WIDTH  divisor
//   res_valid    out  1      q and r are valid (DONE only)
//   res_ready    in   1      consumer accepts the result
//   q            out  WIDTH  quotient
//   r            out  WIDTH  remainder
//   busy         out  1      high in RUN and DONE
//   dz           out  1      divide-by-zero flag (only with DIV_BYZERO_EN)
//
// Build option:
//   DIV_BYZERO_EN  when defined, b == 0 bypasses the iterations, goes to DONE
//                  on the acceptance edge with q = all ones, r = a, dz = 1.
//                  When undefined there is no dz port and b == 0 runs the full
//                  iteration count, which naturally yields q = all ones, r = a.
module alu_div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy
`ifdef DIV_BYZERO_EN
    ,
    output logic             dz
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] d_reg;    // dividend shift register, holds q at the end
    logic [WIDTH-1:0] b_reg;    // latched divisor
    // The partial remainder is always < B after each iteration, so its
    // top (WIDTH) bit is always zero and is not stored.
    logic [WIDTH-1:0] p_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   s_val;    // shifted partial remainder
    logic [WIDTH-1:0] t_val;    // trial difference, low WIDTH bits
    logic [WIDTH:0]   bc;       // borrow chain, bc[0] is borrow-in
    logic             borrow;
    logic [WIDTH-1:0] p_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             accept;
    logic             zero_div;

    // Trial subtraction S - {0,B}: ripple borrow chain over the low WIDTH bits.
    // The subtrahend's top bit is zero, so the final stage only has to fold
    // S[WIDTH] into the borrow-out; its difference bit is never needed.
    always_comb begin
        s_val = {p_reg, d_reg[WIDTH-1]};
        t_val = '0;
        bc    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            t_val[i] = s_val[i] ^ b_reg[i] ^ bc[i];
            bc[i+1]  = (~s_val[i] & b_reg[i]) | (~(s_val[i] ^ b_reg[i]) & bc[i]);
        end
        borrow = ~s_val[WIDTH] & bc[WIDTH];
        p_nxt  = borrow ? s_val[WIDTH-1:0] : t_val;
        d_nxt  = {d_reg[WIDTH-2:0], ~borrow};
    end

`ifdef DIV_BYZERO_EN
    assign zero_div = (b == '0);
`else
    assign zero_div = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                accept      = start_valid;
                if (start_valid) begin
                    state_nxt = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
`ifdef DIV_BYZERO_EN
            dz    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        d_reg <= a;
                        b_reg <= b;
                        p_reg <= '0;
                        cnt   <= CW'(WIDTH - 1);
`ifdef DIV_BYZERO_EN
                        if (zero_div) begin
                            q  <= '1;
                            r  <= a;
                            dz <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    p_reg <= p_nxt;
                    d_reg <= d_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        q <= d_nxt;
                        r <= p_nxt;
                    end
                end
                DONE: begin
`ifdef DIV_BYZERO_EN
                    if (res_ready) begin
                        dz <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div8_seq.sv
// tb_alu_div8_seq - directed self-checking bench for alu_div8_seq.
// Expected results are pushed to a scoreboard queue at operand acceptance and
// popped when the divider presents a result.
module tb_alu_div8_seq;

    localparam int W = 8;
`ifdef DIV_BYZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
`ifdef DIV_BYZERO_EN
    logic         dz;
`endif

    alu_div8_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .q           (q),
        .r           (r),
        .busy        (busy)
`ifdef DIV_BYZERO_EN
        ,
        .dz          (dz)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           acc;
        int           lat;
        logic         dz;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input int acc);
        exp_t e;
        e.acc = acc;
        if (bb == 0) begin
            e.q   = 8'hFF;
            e.r   = aa;
            e.lat = DZ_EN ? 0 : W;   // DONE is entered on the acceptance edge itself
            e.dz  = DZ_EN;
        end else begin
            e.q   = aa / bb;
            e.r   = aa % bb;
            e.lat = W;
            e.dz  = 1'b0;
        end
        return e;
    endfunction

    // Starts and ends just after a falling edge.
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb);
        check("start_ready_before_send", start_ready, 1);
        a = aa;
        b = bb;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        sb.push_back(model(aa, bb, cyc));
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   waited = 0;
        while (res_valid !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("res_valid_rise", res_valid, 1);
        if (res_valid !== 1'b1) return;
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("latency", cyc - e.acc, e.lat);
        check("q", q, e.q);
        check("r", r, e.r);
`ifdef DIV_BYZERO_EN
        check("dz", dz, e.dz);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_start_ready", start_ready, 0);
            check("hold_q", q, e.q);
            check("hold_r", r, e.r);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("post_hs_res_valid", res_valid, 0);
        check("post_hs_busy", busy, 0);
        check("post_hs_start_ready", start_ready, 1);
        check("post_hs_q_kept", q, e.q);
        check("post_hs_r_kept", r, e.r);
`ifdef DIV_BYZERO_EN
        check("post_hs_dz", dz, 0);
`endif
    endtask

    initial begin
        logic [W-1:0] pa[3];
        logic [W-1:0] pb[3];
        int           acc_t[3];
        int           na;
        int           nr;
        logic         accepting;
        exp_t         e;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
`ifdef DIV_BYZERO_EN
        check("rst_dz", dz, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_start_ready", start_ready, 1);

        // 200/7 with operand and start_valid noise during RUN
        send(8'd200, 8'd7);
        for (int i = 0; i < 4; i++) begin
            check("run_start_ready", start_ready, 0);
            check("run_busy", busy, 1);
            check("run_res_valid", res_valid, 0);
            a = W'($urandom);
            b = W'($urandom);
            start_valid = (i % 2) == 0;
            @(negedge clk);
        end
        start_valid = 1'b0;
        collect(0);

        // Directed corner operands
        send(8'd255, 8'd1);   collect(0);
        send(8'd5,   8'd9);   collect(0);
        send(8'd255, 8'd255); collect(0);
        send(8'd77,  8'd0);   collect(0);

        // Back-pressure in DONE
        send(8'd100, 8'd3);   collect(5);

        // Reset at iteration 4 of 200/7
        send(8'd200, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_rst_q", q, 0);
        check("midrun_rst_r", r, 0);
        check("midrun_rst_res_valid", res_valid, 0);
        check("midrun_rst_busy", busy, 0);
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrun_rst_no_result", res_valid, 0);
        end
        check("midrun_rst_start_ready", start_ready, 1);
        send(8'd9, 8'd3);     collect(0);

        // Back-to-back with start_valid and res_ready held high
        pa[0] = 8'd100; pb[0] = 8'd10;
        pa[1] = 8'd250; pb[1] = 8'd3;
        pa[2] = 8'd17;  pb[2] = 8'd17;
        na = 0;
        nr = 0;
        a = pa[0];
        b = pb[0];
        start_valid = 1'b1;
        res_ready   = 1'b1;
        for (int t = 0; t < 100 && nr < 3; t++) begin
            accepting = start_valid && start_ready;
            if (res_valid === 1'b1) begin
                check("b2b_sb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("b2b_latency", cyc - e.acc, e.lat);
                    check("b2b_q", q, e.q);
                    check("b2b_r", r, e.r);
                end
                nr++;
            end
            @(negedge clk);
            if (accepting) begin
                acc_t[na] = cyc;
                sb.push_back(model(pa[na], pb[na], cyc));
                na++;
                if (na < 3) begin
                    a = pa[na];
                    b = pb[na];
                end else begin
                    start_valid = 1'b0;
                end
            end
        end
        start_valid = 1'b0;
        res_ready   = 1'b0;
        check("b2b_results", nr, 3);
        check("b2b_accepts", na, 3);
        if (na == 3) begin
            check("b2b_spacing_01", acc_t[1] - acc_t[0], W + 2);
            check("b2b_spacing_12", acc_t[2] - acc_t[1], W + 2);
        end

        // Random nonzero divisors
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom_range(1, 255)));
            collect(i % 3);
        end

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
